// File: rtl/sinegen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sinegen_pkg
//  Description : Shared types and reset-value helpers for the sine-wave
//                generator address path (FSM state encoding, default
//                increment and phase offset as functions of the widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package sinegen_pkg;

    // Configuration-update FSM: STOPPED and RUN accept a new configuration;
    // PEND holds a shadow configuration until the next waveform wrap.
    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUN     = 2'd1,
        PEND    = 2'd2
    } state_t;

    // One ROM address per enabled cycle: the integer part of the step is 1.
    function automatic logic [63:0] default_incr(input int fw);
        return 64'd1 << fw;
    endfunction

    // Quarter of the table, so port 2 reads the cosine of port 1's sine.
    function automatic logic [63:0] default_offset(input int aw);
        return 64'd1 << (aw - 2);
    endfunction

endpackage : sinegen_pkg
`default_nettype wire

// File: rtl/phase_acc.sv
`default_nettype none
// ============================================================================
//  Module      : phase_acc
//  Description : Fractional phase accumulator with carry-out. Holds when not
//                enabled and registers both ROM addresses (port 2 offset by a
//                programmable phase) plus a one-cycle wrap pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_acc
    import sinegen_pkg::*;
#(
    parameter int                         ADDRESS_WIDTH = 8,
    parameter int                         FRAC_WIDTH    = 8,
    parameter logic [ADDRESS_WIDTH-1:0]   RST_ADDR2     = '0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_en,
    input  logic [ADDRESS_WIDTH+FRAC_WIDTH-1:0]  i_incr,
    input  logic [ADDRESS_WIDTH-1:0]             i_offset,
    output logic                                 o_carry,
    output logic [ADDRESS_WIDTH-1:0]             o_addr1,
    output logic [ADDRESS_WIDTH-1:0]             o_addr2,
    output logic                                 o_wrap
);

    localparam int c_acc_width = ADDRESS_WIDTH + FRAC_WIDTH;

    logic [c_acc_width-1:0]    r_acc;
    logic [ADDRESS_WIDTH-1:0]  r_addr1;
    logic [ADDRESS_WIDTH-1:0]  r_addr2;
    logic                      r_wrap;

    logic [c_acc_width:0]      w_sum;
    logic [c_acc_width-1:0]    w_acc_next;
    logic [ADDRESS_WIDTH-1:0]  w_addr_next;

    // One extra bit on the adder captures the modulo-2^ACC overflow.
    assign w_sum       = {1'b0, r_acc} + {1'b0, i_incr};
    assign w_acc_next  = i_en ? w_sum[c_acc_width-1:0] : r_acc;
    assign o_carry     = i_en & w_sum[c_acc_width];
    assign w_addr_next = w_acc_next[c_acc_width-1:FRAC_WIDTH];

    // Accumulate on enable; addresses and wrap are registered so the ROM
    // sees no combinational path from the enable or configuration inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_addr1 <= '0;
            r_addr2 <= RST_ADDR2;
            r_wrap  <= 1'b0;
        end else begin
            r_acc   <= w_acc_next;
            r_addr1 <= w_addr_next;
            r_addr2 <= w_addr_next + i_offset;
            r_wrap  <= o_carry;
        end
    end

    assign o_addr1 = r_addr1;
    assign o_addr2 = r_addr2;
    assign o_wrap  = r_wrap;

endmodule : phase_acc
`default_nettype wire

// File: rtl/sinegen_addr.sv
`default_nettype none
// ============================================================================
//  Module      : sinegen_addr
//  Description : Address generator for the dual-port sine ROM. Owns the
//                active/shadow configuration, the valid/ready handshake and
//                the FSM that defers running-time updates to the next wrap so
//                frequency/offset changes are glitch-free.
//  Revision    : 1.0 - initial release
// ============================================================================
module sinegen_addr
    import sinegen_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int FRAC_WIDTH    = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic [ADDRESS_WIDTH+FRAC_WIDTH-1:0]  cfg_incr,
    input  logic [ADDRESS_WIDTH-1:0]             cfg_offset,
    output logic [ADDRESS_WIDTH-1:0]             addr1,
    output logic [ADDRESS_WIDTH-1:0]             addr2,
    output logic                                 wrap
);

    localparam int                       c_acc_width   = ADDRESS_WIDTH + FRAC_WIDTH;
    localparam logic [c_acc_width-1:0]   c_rst_incr    = c_acc_width'(default_incr(FRAC_WIDTH));
    localparam logic [ADDRESS_WIDTH-1:0] c_rst_offset  = ADDRESS_WIDTH'(default_offset(ADDRESS_WIDTH));

    state_t                      r_state;
    state_t                      w_state_next;

    logic [c_acc_width-1:0]      r_incr_act;
    logic [ADDRESS_WIDTH-1:0]    r_offset_act;
    logic [c_acc_width-1:0]      r_incr_sh;
    logic [ADDRESS_WIDTH-1:0]    r_offset_sh;

    logic                        w_accept;
    logic                        w_carry;
    logic                        w_incr_zero;
    logic                        w_load_act_cfg;
    logic                        w_load_act_sh;
    logic                        w_load_sh;

    // Ready depends on state only, so it never loops back through cfg_valid.
    assign cfg_ready   = (r_state != PEND);
    assign w_accept    = cfg_valid & cfg_ready;
    // With a zero step a wrap can never arrive, so a pending update must not wait.
    assign w_incr_zero = (r_incr_act == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= STOPPED;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and configuration-load decisions.
    always_comb begin
        w_state_next   = r_state;
        w_load_act_cfg = 1'b0;
        w_load_act_sh  = 1'b0;
        w_load_sh      = 1'b0;
        case (r_state)
            STOPPED: begin
                w_load_act_cfg = w_accept;
                w_state_next   = en ? RUN : STOPPED;
            end
            RUN: begin
                if (w_accept && en) begin
                    // Running: park the new values until the waveform wraps.
                    w_load_sh    = 1'b1;
                    w_state_next = PEND;
                end else begin
                    // Stopping this cycle: no phase glitch possible, apply now.
                    w_load_act_cfg = w_accept;
                    w_state_next   = en ? RUN : STOPPED;
                end
            end
            PEND: begin
                if (w_carry || !en || w_incr_zero) begin
                    w_load_act_sh = 1'b1;
                    w_state_next  = en ? RUN : STOPPED;
                end
            end
            default: begin
                w_state_next = STOPPED;
            end
        endcase
    end

    // Active and shadow configuration; reset drops any pending update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_incr_act   <= c_rst_incr;
            r_offset_act <= c_rst_offset;
            r_incr_sh    <= c_rst_incr;
            r_offset_sh  <= c_rst_offset;
        end else begin
            if (w_load_act_cfg) begin
                r_incr_act   <= cfg_incr;
                r_offset_act <= cfg_offset;
            end else if (w_load_act_sh) begin
                r_incr_act   <= r_incr_sh;
                r_offset_act <= r_offset_sh;
            end
            if (w_load_sh) begin
                r_incr_sh    <= cfg_incr;
                r_offset_sh  <= cfg_offset;
            end
        end
    end

    phase_acc #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .FRAC_WIDTH    (FRAC_WIDTH),
        .RST_ADDR2     (c_rst_offset)
    ) u_phase_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (en),
        .i_incr   (r_incr_act),
        .i_offset (r_offset_act),
        .o_carry  (w_carry),
        .o_addr1  (addr1),
        .o_addr2  (addr2),
        .o_wrap   (wrap)
    );

endmodule : sinegen_addr
`default_nettype wire

// File: tb/tb_sinegen_addr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sinegen_addr
//  Description : Directed bench for sinegen_addr (AW=8, FW=8). A small
//                behavioural model queues the expected addresses/wrap per
//                driven cycle; directed checks cover the scenario milestones.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sinegen_addr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_incr;
    logic [7:0]  cfg_offset;
    logic [7:0]  addr1;
    logic [7:0]  addr2;
    logic        wrap;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] a1;
        logic [7:0] a2;
        logic       w;
    } exp_t;
    exp_t q_exp[$];

    // Reference model state (0 = stopped, 1 = run, 2 = pending).
    int m_acc, m_incr, m_off, m_sh_incr, m_sh_off, m_state;

    sinegen_addr #(
        .ADDRESS_WIDTH (8),
        .FRAC_WIDTH    (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_incr   (cfg_incr),
        .cfg_offset (cfg_offset),
        .addr1      (addr1),
        .addr2      (addr2),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc     = 0;
        m_incr    = 256;
        m_off     = 64;
        m_sh_incr = 256;
        m_sh_off  = 64;
        m_state   = 0;
    endtask

    // Drive one clock cycle of stimulus, predict the outputs, then compare.
    task automatic cycle(input logic e, input logic v, input logic [15:0] inc, input logic [7:0] off);
        int   sum;
        int   a1;
        bit   carry;
        bit   ready;
        bit   acc_ok;
        exp_t x;
        exp_t got;
        en         = e;
        cfg_valid  = v;
        cfg_incr   = inc;
        cfg_offset = off;
        ready = (m_state != 2);
        check("cfg_ready", {31'd0, cfg_ready}, {31'd0, ready});
        sum   = m_acc + (e ? m_incr : 0);
        carry = (sum >= 65536);
        m_acc = sum % 65536;
        a1    = m_acc / 256;
        x.a1  = a1[7:0];
        sum   = (a1 + m_off) % 256;
        x.a2  = sum[7:0];
        x.w   = carry;
        q_exp.push_back(x);
        acc_ok = v && ready;
        case (m_state)
            0: begin
                if (acc_ok) begin m_incr = int'(inc); m_off = int'(off); end
                m_state = e ? 1 : 0;
            end
            1: begin
                if (acc_ok && e) begin
                    m_sh_incr = int'(inc); m_sh_off = int'(off); m_state = 2;
                end else begin
                    if (acc_ok) begin m_incr = int'(inc); m_off = int'(off); end
                    m_state = e ? 1 : 0;
                end
            end
            default: begin
                if (carry || !e || m_incr == 0) begin
                    m_incr = m_sh_incr; m_off = m_sh_off; m_state = e ? 1 : 0;
                end
            end
        endcase
        @(posedge clk);
        #1;
        got = q_exp.pop_front();
        check("addr1", {24'd0, addr1}, {24'd0, got.a1});
        check("addr2", {24'd0, addr2}, {24'd0, got.a2});
        check("wrap",  {31'd0, wrap},  {31'd0, got.w});
    endtask

    initial begin
        int         first_wrap;
        int         nwraps;
        bit         seen;
        logic [7:0] prev;
        logic [7:0] frozen;

        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_incr = '0; cfg_offset = '0;
        model_reset();

        // Reset values held while rst_n is low.
        #1;
        check("rst_addr1_async", {24'd0, addr1}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr1", {24'd0, addr1}, 32'd0);
        check("rst_addr2", {24'd0, addr2}, 32'd64);
        check("rst_wrap",  {31'd0, wrap},  32'd0);
        check("rst_ready", {31'd0, cfg_ready}, 32'd1);
        rst_n = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, 16'h0, 8'h0);

        // Default run: step 1, cosine offset, wrap on the 256th cycle.
        first_wrap = -1;
        for (int k = 1; k <= 260; k++) begin
            cycle(1'b1, 1'b0, 16'h0, 8'h0);
            if (wrap === 1'b1 && first_wrap < 0) first_wrap = k;
        end
        check("default_first_wrap", first_wrap, 32'd256);
        cycle(1'b0, 1'b0, 16'h0, 8'h0);

        // Configuration accepted while stopped: half step, zero offset.
        cycle(1'b0, 1'b1, 16'h0080, 8'd0);
        first_wrap = -1;
        for (int k = 1; k <= 520; k++) begin
            cycle(1'b1, 1'b0, 16'h0, 8'h0);
            if (wrap === 1'b1 && first_wrap < 0) first_wrap = k;
        end
        // Started from addr1=4, so the wrap lands 8 half-steps before 512.
        check("stopped_cfg_first_wrap", first_wrap, 32'd504);
        check("stopped_cfg_addr2_eq", {24'd0, addr2}, {24'd0, addr1});

        // Accept while running with en=0 applies directly; then defer an update.
        cycle(1'b0, 1'b1, 16'h0100, 8'd64);
        for (int k = 0; k < 20 && addr1 != 8'd10; k++) cycle(1'b1, 1'b0, 16'h0, 8'h0);
        check("defer_start_addr1", {24'd0, addr1}, 32'd10);
        cycle(1'b1, 1'b1, 16'h0200, 8'd64);
        check("defer_ready_low", {31'd0, cfg_ready}, 32'd0);
        seen = 1'b0;
        prev = addr1;
        for (int k = 0; k < 300; k++) begin
            prev = addr1;
            cycle(1'b1, 1'b0, 16'h0, 8'h0);
            if (wrap === 1'b1) begin seen = 1'b1; break; end
        end
        check("defer_wrap_seen",   {31'd0, seen}, 32'd1);
        check("defer_pre_wrap",    {24'd0, prev}, 32'd255);
        check("defer_wrap_addr1",  {24'd0, addr1}, 32'd0);
        check("defer_ready_back",  {31'd0, cfg_ready}, 32'd1);
        cycle(1'b1, 1'b0, 16'h0, 8'h0);
        check("defer_step2_a", {24'd0, addr1}, 32'd2);
        cycle(1'b1, 1'b0, 16'h0, 8'h0);
        check("defer_step2_b", {24'd0, addr1}, 32'd4);

        // Zero step: pending update must apply without waiting for a wrap.
        cycle(1'b0, 1'b0, 16'h0, 8'h0);
        cycle(1'b0, 1'b1, 16'h0000, 8'd64);
        cycle(1'b1, 1'b0, 16'h0, 8'h0);
        cycle(1'b1, 1'b0, 16'h0, 8'h0);
        frozen = addr1;
        cycle(1'b1, 1'b1, 16'h0100, 8'd64);
        check("zero_frozen_a", {24'd0, addr1}, {24'd0, frozen});
        check("zero_pend_ready", {31'd0, cfg_ready}, 32'd0);
        cycle(1'b1, 1'b0, 16'h0, 8'h0);
        check("zero_frozen_b", {24'd0, addr1}, {24'd0, frozen});
        check("zero_ready_back", {31'd0, cfg_ready}, 32'd1);
        cycle(1'b1, 1'b0, 16'h0, 8'h0);
        frozen = frozen + 8'd1;
        check("zero_step_applied", {24'd0, addr1}, {24'd0, frozen});

        // Asynchronous reset while an update is pending.
        cycle(1'b1, 1'b1, 16'h0300, 8'd10);
        repeat (3) cycle(1'b1, 1'b0, 16'h0, 8'h0);
        check("pend_ready_low", {31'd0, cfg_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_addr1", {24'd0, addr1}, 32'd0);
        check("async_rst_addr2", {24'd0, addr2}, 32'd64);
        check("async_rst_wrap",  {31'd0, wrap},  32'd0);
        check("async_rst_ready", {31'd0, cfg_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (5) cycle(1'b1, 1'b0, 16'h0, 8'h0);
        check("post_rst_addr1", {24'd0, addr1}, 32'd5);
        check("post_rst_addr2", {24'd0, addr2}, 32'd69);

        // Large step: carries on consecutive cycles give adjacent wrap pulses.
        cycle(1'b0, 1'b1, 16'hC000, 8'd0);
        nwraps = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 1'b0, 16'h0, 8'h0);
            if (wrap === 1'b1) nwraps++;
        end
        check("b2b_wrap_count", nwraps, 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_sinegen_addr
`default_nettype wire

// File: doc/sinegen_addr.md
# sinegen_addr

Phase-accumulator address generator for the sine-wave generator datapath. It drives the two address ports of the dual-port sine ROM (`addr1`, `addr2`) from a fractional-step accumulator. `addr2` is a programmable phase offset from `addr1`. Frequency and offset are reconfigured through a valid/ready handshake, and changes are applied glitch-free at the next waveform wrap.

## Interface
- `ADDRESS_WIDTH`, default 8: ROM address width (AW).
- `FRAC_WIDTH`, default 8: fractional phase bits (FW). The accumulator width is ACC = AW+FW.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `en`  in  1: advance the accumulator this cycle.
- `cfg_valid`  in  1: new configuration offered.
- `cfg_ready`  out  1: configuration can be accepted.
- `cfg_incr`  in  ACC: phase step per enabled cycle.
- `cfg_offset`  in  AW: phase offset applied to `addr2`.
- `addr1`  out  AW: ROM port-1 address.
- `addr2`  out  AW: ROM port-2 address.
- `wrap`  out  1: one-cycle pulse marking an accumulator wrap.

## Operation
- Registers:
  - `acc` (ACC bits)
  - `incr_act`, `offset_act` (active configuration)
  - `incr_sh`, `offset_sh` (shadow configuration)
  - state
- Accumulation:
  - On each cycle with `en`=1: `acc <= (acc + incr_act) mod 2^ACC`. Carry = the sum ≥ 2^ACC.
  - `en`=0 holds `acc`.
- Address outputs (registered):
  - `addr1 <= acc_next[ACC-1:FW]`.
  - `addr2 <= (acc_next[ACC-1:FW] + offset_act) mod 2^AW`.
  - Both use the `offset_act` value in effect during the update cycle.
- `wrap` is registered: it is 1 in the cycle after a carry, aligned with the wrapped `addr1`.
- Handshake: a configuration is accepted when `cfg_valid && cfg_ready`. `cfg_ready` is decoded combinationally from state.
- States:
  - STOPPED (`cfg_ready`=1):
    - An accepted configuration is copied to the active registers (effective from the next cycle).
    - Go to RUN when `en`=1.
  - RUN (`cfg_ready`=1):
    - An accepted configuration goes to the shadow registers, then PEND.
    - Go to STOPPED when `en`=0 (acceptance has priority: accept with `en`=0 applies directly, then STOPPED).
  - PEND (`cfg_ready`=0):
    - On the cycle a carry occurs, the shadow is copied to active, then RUN.
    - If `en`=0, or `incr_act`==0 (a wrap can never occur), the shadow is applied immediately, then STOPPED/RUN accordingly.
- A carry in the same cycle as acceptance in RUN uses the old increment. The new configuration waits for the next wrap.
- Active-configuration changes never reset `acc`; phase is continuous.
- Reset values:
  - `acc`=0
  - `incr_act`=`incr_sh`=1<<FW (one address per cycle)
  - `offset_act`=`offset_sh`=2^(AW-2) (quarter wave, giving cosine on `addr2`)
  - `addr1`=0, `addr2`=2^(AW-2), `wrap`=0
  - state STOPPED, so `cfg_ready`=1
- Reset mid-operation discards any pending shadow configuration.

## Timing
- `addr1`/`addr2` change one cycle after the `en` cycle. The ROM adds one more cycle, so ROM data follows `en` by 2 cycles.
- Configuration accepted in STOPPED affects the step on the first `en` cycle after acceptance.
- Configuration accepted in RUN takes effect on the cycle after the wrap. `cfg_ready` returns to 1 in that same cycle.
- `wrap` is exactly one cycle wide per carry. Back-to-back carries (incr ≥ 2^(ACC-1) alternating) give back-to-back pulses.
- No combinational path from `cfg_*` or `en` to `addr1`/`addr2`/`wrap`.

## Structure
- `sinegen_pkg`:
  - state enum (STOPPED, RUN, PEND)
  - `DEFAULT_INCR`/`DEFAULT_OFFSET` as functions of AW/FW
- One sub-module, `phase_acc`: ACC-bit adder with carry-out, hold-on-`!en`, registered address/offset outputs.
- `sinegen_addr` owns the FSM, shadow/active registers and the handshake.

## Test plan
All scenarios use AW=8, FW=8.
- Reset: hold `rst_n`=0 → `addr1`=0, `addr2`=64, `wrap`=0, `cfg_ready`=1. Assert `rst_n` with `en`=0 → outputs hold.
- Default run: `en`=1 for 260 cycles → `addr1` steps by 1 each cycle, `addr2`==`addr1`+64 mod 256. `wrap`=1 only in the cycle `addr1` returns to 0 (cycle 256).
- STOPPED configuration: accept `incr`=0x0080, `offset`=0, then `en`=1 → `addr1` advances every 2 cycles, `addr2`==`addr1`, first wrap after 512 cycles.
- Deferred update: in RUN at `addr1`=10, accept `incr`=0x0200 → `cfg_ready`=0, step stays 1 through `addr1`=255. After the wrap, step is 2 (0, 2, 4…) and `cfg_ready`=1.
- Zero step: active `incr`=0 in RUN, accept `incr`=0x0100 → `addr1` frozen, new step applied the next cycle, no `wrap`.
- Reset in PEND: accept a new configuration mid-run, pull `rst_n` low before the wrap → reset values restored immediately (async). After release, the default step and offset are in effect.
